// File: rtl/ycbcr_to_rgb.sv
// ycbcr_to_rgb
// Four-stage pipelined converter from 8-bit studio-range YCbCr to 8-bit
// full-range RGB. It uses the inverse of the forward path's BT.709-style
// coefficients. The valid and sync strobes ride a matched 4-deep delay line,
// so the timing outputs stay aligned with the pixel they belong to.
//
// Ports
//   clk                       rising-edge clock for all logic
//   rst                       synchronous active-high reset, clears everything
//   i_vld, i_hs, i_vs         input valid / horizontal sync / vertical sync
//   i_y_8b, i_cb_8b, i_cr_8b  input luma and chroma samples
//   o_vld, o_hs, o_vs         inputs delayed by exactly 4 cycles
//   o_r_8b, o_g_8b, o_b_8b    converted colour, valid only when o_vld = 1
//
// Coefficient parameters are x256 fixed point and unsigned.
module ycbcr_to_rgb #(
    parameter int K_Y   = 298,
    parameter int K_RCR = 459,
    parameter int K_GCB = 55,
    parameter int K_GCR = 136,
    parameter int K_BCB = 541
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_vld,
    input  logic       i_hs,
    input  logic       i_vs,
    input  logic [7:0] i_y_8b,
    input  logic [7:0] i_cb_8b,
    input  logic [7:0] i_cr_8b,
    output logic       o_vld,
    output logic       o_hs,
    output logic       o_vs,
    output logic [7:0] o_r_8b,
    output logic [7:0] o_g_8b,
    output logic [7:0] o_b_8b
);

    // Coefficients are widened to the 20-bit datapath width. This keeps
    // every product and sum signed at full width, so no stage can wrap.
    localparam logic signed [19:0] KY   = 20'(K_Y);
    localparam logic signed [19:0] KRCR = 20'(K_RCR);
    localparam logic signed [19:0] KGCB = 20'(K_GCB);
    localparam logic signed [19:0] KGCR = 20'(K_GCR);
    localparam logic signed [19:0] KBCB = 20'(K_BCB);

    // Stage 1: offset-removed components
    logic signed [8:0]  yd, cbd, crd;
    // Stage 2: products
    logic signed [19:0] p_y, p_rcr, p_gcb, p_gcr, p_bcb;
    // Stage 3: rounded sums
    logic signed [19:0] s_r, s_g, s_b;
    // Strobe delay lines, bit 3 is the output tap
    logic [3:0]         vld_sr, hs_sr, vs_sr;

    // Divide by 256 with the arithmetic shift, then clamp. The sum is
    // non-negative by the time the upper bits are examined, so any set bit
    // in [18:16] means the shifted value exceeds 255.
    function automatic logic [7:0] clamp8(input logic signed [19:0] s);
        logic signed [19:0] v;
        v = s >>> 8;
        if (s[19])
            clamp8 = 8'd0;
        else if (|v[18:8])
            clamp8 = 8'd255;
        else
            clamp8 = v[7:0];
    endfunction

    // Stage 1: remove the studio-range offsets.
    always_ff @(posedge clk) begin
        if (rst) begin
            yd  <= '0;
            cbd <= '0;
            crd <= '0;
        end else begin
            yd  <= $signed({1'b0, i_y_8b})  - 9'sd16;
            cbd <= $signed({1'b0, i_cb_8b}) - 9'sd128;
            crd <= $signed({1'b0, i_cr_8b}) - 9'sd128;
        end
    end

    // Stage 2: the five coefficient products.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_y   <= '0;
            p_rcr <= '0;
            p_gcb <= '0;
            p_gcr <= '0;
            p_bcb <= '0;
        end else begin
            p_y   <= KY   * 20'(yd);
            p_rcr <= KRCR * 20'(crd);
            p_gcb <= KGCB * 20'(cbd);
            p_gcr <= KGCR * 20'(crd);
            p_bcb <= KBCB * 20'(cbd);
        end
    end

    // Stage 3: channel sums. The +128 term turns the later shift into
    // round-half-up.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_r <= '0;
            s_g <= '0;
            s_b <= '0;
        end else begin
            s_r <= p_y + p_rcr + 20'sd128;
            s_g <= p_y - p_gcb - p_gcr + 20'sd128;
            s_b <= p_y + p_bcb + 20'sd128;
        end
    end

    // Stage 4: scale and clamp into the output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_r_8b <= '0;
            o_g_8b <= '0;
            o_b_8b <= '0;
        end else begin
            o_r_8b <= clamp8(s_r);
            o_g_8b <= clamp8(s_g);
            o_b_8b <= clamp8(s_b);
        end
    end

    // Strobe delay lines. They match the four data stages so sync edges
    // stay locked to their pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr <= '0;
            hs_sr  <= '0;
            vs_sr  <= '0;
        end else begin
            vld_sr <= {vld_sr[2:0], i_vld};
            hs_sr  <= {hs_sr[2:0],  i_hs};
            vs_sr  <= {vs_sr[2:0],  i_vs};
        end
    end

    assign o_vld = vld_sr[3];
    assign o_hs  = hs_sr[3];
    assign o_vs  = vs_sr[3];

endmodule

// File: tb/tb_ycbcr_to_rgb.sv
// tb_ycbcr_to_rgb
// Scoreboard bench for ycbcr_to_rgb. Each driven cycle pushes its expected
// output word {vld, hs, vs, r, g, b} with the cycle index where it is due.
// The test tasks pop the due entries and compare them against the DUT.
module tb_ycbcr_to_rgb;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_vld, i_hs, i_vs;
    logic [7:0] i_y_8b, i_cb_8b, i_cr_8b;
    logic       o_vld, o_hs, o_vs;
    logic [7:0] o_r_8b, o_g_8b, o_b_8b;

    typedef struct {
        int          due;
        logic [26:0] exp;
        bit          full;
    } exp_t;

    exp_t sb[$];
    int   ticks   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    ycbcr_to_rgb dut (
        .clk     (clk),
        .rst     (rst),
        .i_vld   (i_vld),
        .i_hs    (i_hs),
        .i_vs    (i_vs),
        .i_y_8b  (i_y_8b),
        .i_cb_8b (i_cb_8b),
        .i_cr_8b (i_cr_8b),
        .o_vld   (o_vld),
        .o_hs    (o_hs),
        .o_vs    (o_vs),
        .o_r_8b  (o_r_8b),
        .o_g_8b  (o_g_8b),
        .o_b_8b  (o_b_8b)
    );

    // Reference conversion in plain integer arithmetic
    function automatic logic [7:0] ref_clamp(input int s);
        int v;
        if (s < 0) return 8'd0;
        v = s / 256;
        if (v > 255) return 8'd255;
        return 8'(v);
    endfunction

    function automatic logic [23:0] ref_rgb(input int y, input int cb, input int cr);
        int yd, cbd, crd;
        yd  = y - 16;
        cbd = cb - 128;
        crd = cr - 128;
        return {ref_clamp(298 * yd + 459 * crd + 128),
                ref_clamp(298 * yd - 55 * cbd - 136 * crd + 128),
                ref_clamp(298 * yd + 541 * cbd + 128)};
    endfunction

    // Drives one cycle and records its expectation. A reset cycle flushes
    // the scoreboard and expects all-zero outputs for four cycles.
    // use_const selects caller-supplied RGB values instead of the model.
    task automatic tick(input logic r, input logic v, input logic hs, input logic vs,
                        input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                        input bit use_const, input logic [23:0] const_rgb);
        exp_t e;
        int   idx;
        idx     = ticks;
        rst     = r;
        i_vld   = v;
        i_hs    = hs;
        i_vs    = vs;
        i_y_8b  = y;
        i_cb_8b = cb;
        i_cr_8b = cr;
        if (r) begin
            sb.delete();
            for (int k = 0; k < 4; k++) begin
                e.due  = idx + k;
                e.exp  = '0;
                e.full = 1'b1;
                sb.push_back(e);
            end
        end else begin
            e.due  = idx + 3;
            e.exp  = {v, hs, vs, use_const ? const_rgb : ref_rgb(int'(y), int'(cb), int'(cr))};
            e.full = 1'b0;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        ticks++;
    endtask

    task automatic test_reset();
        exp_t        e;
        logic [26:0] obs;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 24'd0);
            while (sb.size() > 0 && sb[0].due == ticks - 1) begin
                e   = sb.pop_front();
                obs = {o_vld, o_hs, o_vs, o_r_8b, o_g_8b, o_b_8b};
                n_checks++;
                if (obs !== e.exp) begin
                    n_fail++;
                    $display("[TB] FAIL reset_state cycle %0d: got %h expected %h", ticks - 1, obs, e.exp);
                end
            end
        end
    endtask

    task automatic test_colors();
        exp_t        e;
        logic [26:0] obs;
        logic [47:0] vec [5];
        // {Y, Cb, Cr, R, G, B}
        vec[0] = {8'd16,  8'd128, 8'd128, 8'd0,   8'd0,   8'd0};
        vec[1] = {8'd235, 8'd128, 8'd128, 8'd255, 8'd255, 8'd255};
        vec[2] = {8'd126, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128};
        vec[3] = {8'd235, 8'd128, 8'd240, 8'd255, 8'd195, 8'd255};
        vec[4] = {8'd16,  8'd128, 8'd16,  8'd0,   8'd60,  8'd0};
        for (int i = 0; i < 9; i++) begin
            if (i < 5)
                tick(1'b0, 1'b1, 1'b0, 1'b0, vec[i][47:40], vec[i][39:32], vec[i][31:24],
                     1'b1, vec[i][23:0]);
            else
                tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd16, 8'd128, 8'd128, 1'b0, 24'd0);
            while (sb.size() > 0 && sb[0].due == ticks - 1) begin
                e   = sb.pop_front();
                obs = {o_vld, o_hs, o_vs, o_r_8b, o_g_8b, o_b_8b};
                n_checks++;
                if (e.full || e.exp[26]) begin
                    if (obs !== e.exp) begin
                        n_fail++;
                        $display("[TB] FAIL colors cycle %0d: got %h expected %h", ticks - 1, obs, e.exp);
                    end
                end else if (obs[26:24] !== e.exp[26:24]) begin
                    n_fail++;
                    $display("[TB] FAIL colors_strobes cycle %0d: got %b expected %b",
                             ticks - 1, obs[26:24], e.exp[26:24]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [26:0] obs;
        logic [15:0] pattern;
        pattern = 16'b1101_1110_0111_1011;
        for (int i = 0; i < 20; i++) begin
            if (i < 16)
                tick(1'b0, pattern[15 - i], (i >= 5), (i >= 12),
                     8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     8'($urandom_range(0, 255)), 1'b0, 24'd0);
            else
                tick(1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 8'd0, 1'b0, 24'd0);
            while (sb.size() > 0 && sb[0].due == ticks - 1) begin
                e   = sb.pop_front();
                obs = {o_vld, o_hs, o_vs, o_r_8b, o_g_8b, o_b_8b};
                n_checks++;
                if (e.full || e.exp[26]) begin
                    if (obs !== e.exp) begin
                        n_fail++;
                        $display("[TB] FAIL stream cycle %0d: got %h expected %h", ticks - 1, obs, e.exp);
                    end
                end else if (obs[26:24] !== e.exp[26:24]) begin
                    n_fail++;
                    $display("[TB] FAIL stream_strobes cycle %0d: got %b expected %b",
                             ticks - 1, obs[26:24], e.exp[26:24]);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        exp_t        e;
        logic [26:0] obs;
        for (int i = 0; i < 11; i++) begin
            if (i < 3)
                tick(1'b0, 1'b1, 1'b1, 1'b0, 8'd235, 8'd128, 8'd128, 1'b0, 24'd0);
            else if (i == 3)
                tick(1'b1, 1'b1, 1'b1, 1'b1, 8'd235, 8'd128, 8'd128, 1'b0, 24'd0);
            else if (i == 4)
                tick(1'b0, 1'b1, 1'b1, 1'b0, 8'd126, 8'd128, 8'd128, 1'b1, {3{8'd128}});
            else
                tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd16, 8'd128, 8'd128, 1'b0, 24'd0);
            while (sb.size() > 0 && sb[0].due == ticks - 1) begin
                e   = sb.pop_front();
                obs = {o_vld, o_hs, o_vs, o_r_8b, o_g_8b, o_b_8b};
                n_checks++;
                if (e.full || e.exp[26]) begin
                    if (obs !== e.exp) begin
                        n_fail++;
                        $display("[TB] FAIL reset_midstream cycle %0d: got %h expected %h",
                                 ticks - 1, obs, e.exp);
                    end
                end else if (obs[26:24] !== e.exp[26:24]) begin
                    n_fail++;
                    $display("[TB] FAIL reset_midstream_strobes cycle %0d: got %b expected %b",
                             ticks - 1, obs[26:24], e.exp[26:24]);
                end
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        i_vld   = 1'b0;
        i_hs    = 1'b0;
        i_vs    = 1'b0;
        i_y_8b  = '0;
        i_cb_8b = '0;
        i_cr_8b = '0;
        test_reset();
        test_colors();
        test_back_to_back();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
